eros_ram_bank_arbiter: RTL

//  Round-robin OBI arbiter sharing one single-port SRAM bank (RAM0 or RAM1) among the

---
 rtl/eros_ram_bank_arbiter_pkg.sv | 13 +
 rtl/eros_ram_bank_arbiter_rr_pick.sv | 35 +++
 rtl/eros_ram_bank_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/eros_ram_bank_arbiter_pkg.sv
// Shared constants for the RAM bank arbiter: system sizing, bank map and error response word.
package eros_ram_bank_arbiter_pkg;

  localparam int unsigned SYSTEM_XBAR_NMASTER       = 7;
  localparam logic [31:0] MEMORY_RAM0_START_ADDRESS = 32'h0000_0000;
  localparam int unsigned MEMORY_RAM0_SIZE          = 32'h0000_8000;
  localparam logic [31:0] ERROR_START_ADDRESS       = 32'hBADA_CCE5;

  // Returned to a master whose granted access fell outside the bank.
  localparam logic [31:0] ARB_ERR_RDATA  = ERROR_START_ADDRESS;
  localparam int unsigned CONFLICT_CNT_W = 16;

endpackage

// File: rtl/eros_ram_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, modulo N.
module eros_ram_bank_arbiter_rr_pick #(
  parameter int unsigned N  = 7,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign w_dbl = {i_req, i_req};
  assign w_rot = N'(w_dbl >> i_ptr);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!o_valid && w_rot[k]) begin
        o_valid = 1'b1;
        o_idx   = IW'((32'(i_ptr) + k) % N);
      end
    end
    if (o_valid) begin
      o_onehot[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/eros_ram_bank_arbiter.sv
// Round-robin OBI arbiter sharing one single-port SRAM bank among NMASTER masters,
// with address decode, one-cycle response routing and a saturating contention counter.
module eros_ram_bank_arbiter
  import eros_ram_bank_arbiter_pkg::*;
#(
  parameter int unsigned  NMASTER   = SYSTEM_XBAR_NMASTER,
  parameter logic [31:0]  BANK_BASE = MEMORY_RAM0_START_ADDRESS,
  parameter int unsigned  BANK_SIZE = MEMORY_RAM0_SIZE,
  localparam int unsigned AW        = $clog2(BANK_SIZE / 4)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NMASTER-1:0]        m_req_i,
  input  logic [NMASTER-1:0]        m_we_i,
  input  logic [NMASTER*4-1:0]      m_be_i,
  input  logic [NMASTER*32-1:0]     m_addr_i,
  input  logic [NMASTER*32-1:0]     m_wdata_i,
  output logic [NMASTER-1:0]        m_gnt_o,
  output logic [NMASTER-1:0]        m_rvalid_o,
  output logic [31:0]               m_rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [3:0]                mem_be_o,
  output logic [AW-1:0]             mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [31:0]               mem_rdata_i,
  input  logic                      conflict_clr_i,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt_o,
  output logic                      addr_err_o
);

  localparam int unsigned IW = (NMASTER > 1) ? $clog2(NMASTER) : 1;

  logic [IW-1:0]             r_rr_ptr;
  logic                      r_rsp_valid;
  logic [IW-1:0]             r_rsp_owner;
  logic                      r_rsp_err;
  logic [CONFLICT_CNT_W-1:0] r_conflict_cnt;
  logic                      r_addr_err;

  logic [NMASTER-1:0] w_gnt;
  logic [IW-1:0]      w_idx;
  logic               w_valid;
  logic [31:0]        w_addr;
  logic [31:0]        w_off;
  logic               w_in_range;
  logic [IW-1:0]      w_ptr_next;
  logic               w_conflict;
  logic               w_unused_off;

  eros_ram_bank_arbiter_rr_pick #(
    .N  (NMASTER),
    .IW (IW)
  ) u_rr_pick (
    .i_req    (m_req_i),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_gnt),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  assign w_addr       = m_addr_i[32*w_idx +: 32];
  assign w_off        = w_addr - BANK_BASE;
  assign w_in_range   = (w_addr >= BANK_BASE) && (w_off < BANK_SIZE);
  assign w_unused_off = ^{w_off[31:AW+2], w_off[1:0]};

  // Out-of-range winners are still granted so the master cannot stall; only the SRAM strobe drops.
  assign m_gnt_o     = w_gnt;
  assign mem_req_o   = w_valid && w_in_range;
  assign mem_we_o    = m_we_i[w_idx];
  assign mem_be_o    = m_be_i[4*w_idx +: 4];
  assign mem_addr_o  = w_off[AW+1:2];
  assign mem_wdata_o = m_wdata_i[32*w_idx +: 32];

  assign w_ptr_next = (w_idx == IW'(NMASTER - 1)) ? '0 : w_idx + 1'b1;
  assign w_conflict = ($countones(m_req_i) >= 2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_valid) begin
        r_rr_ptr <= w_ptr_next;
      end
      r_rsp_valid <= w_valid;
      r_rsp_owner <= w_idx;
      r_rsp_err   <= w_valid && !w_in_range;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_conflict_cnt <= '0;
      r_addr_err     <= 1'b0;
    end else begin
      if (conflict_clr_i) begin
        r_conflict_cnt <= '0;
      end else if (w_conflict && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
      if (w_valid && !w_in_range) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  always_comb begin
    m_rvalid_o              = '0;
    m_rvalid_o[r_rsp_owner] = r_rsp_valid;
  end

  assign m_rdata_o      = r_rsp_err ? ARB_ERR_RDATA : mem_rdata_i;
  assign conflict_cnt_o = r_conflict_cnt;
  assign addr_err_o     = r_addr_err;

endmodule
